// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester-side bus of the data-RAM arbiter. It carries the
//               request, write data, grant and tagged read-return signals
//               for one requester.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // The requester drives the access and observes the grant and the read return.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // The arbiter observes the access and drives the grant and the read return.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one single-port synchronous data RAM between the CPU
//               data port (A, favoured) and the video fetch port (B).
//               A saturating wait counter bounds how long B can be starved.
//               Read data returns one cycle after the grant, tagged per
//               requester. A saturating conflict counter is exposed for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  dmem_arbiter_if.slave     a_if,
  dmem_arbiter_if.slave     b_if,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic [15:0]       conflict_cnt_o
);

  localparam logic [3:0]  c_max_wait = 4'(MAX_WAIT);
  localparam logic [15:0] c_cnt_max  = 16'hFFFF;

  logic        w_a_gnt;
  logic        w_b_gnt;
  logic        w_b_starved;

  logic [3:0]  b_wait_q,   b_wait_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;
  logic [15:0] conflict_q, conflict_d;

  // B takes the RAM once it has been denied MAX_WAIT consecutive cycles.
  assign w_b_starved = (b_wait_q == c_max_wait);

  // Grant decision; nothing is granted while reset is held, so no RAM write
  // can happen in a reset cycle.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (reset_ni) begin
      if (b_if.req && (!a_if.req || w_b_starved)) begin
        w_b_gnt = 1'b1;
      end else if (a_if.req) begin
        w_a_gnt = 1'b1;
      end
    end
  end

  // Route the winner's access onto the RAM; idle cycles present all zeros.
  always_comb begin
    ram_wen_o  = 1'b0;
    ram_addr_o = '0;
    ram_din_o  = '0;
    if (w_b_gnt) begin
      ram_wen_o  = b_if.we;
      ram_addr_o = b_if.addr;
      ram_din_o  = b_if.wdata;
    end else if (w_a_gnt) begin
      ram_wen_o  = a_if.we;
      ram_addr_o = a_if.addr;
      ram_din_o  = a_if.wdata;
    end
  end

  // Next-state for the wait counter, read-return flags and conflict counter.
  always_comb begin
    b_wait_d   = b_wait_q;
    conflict_d = conflict_q;
    a_rvalid_d = w_a_gnt && !a_if.we;
    b_rvalid_d = w_b_gnt && !b_if.we;

    if (w_b_gnt || !b_if.req) begin
      b_wait_d = 4'd0;
    end else if (!w_b_starved) begin
      b_wait_d = b_wait_q + 4'd1;
    end

    if (a_if.req && b_if.req && (conflict_q != c_cnt_max)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // State update; a reset edge also drops any read granted in that cycle.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      b_wait_q   <= 4'd0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      conflict_q <= 16'd0;
    end else begin
      b_wait_q   <= b_wait_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      conflict_q <= conflict_d;
    end
  end

  // The RAM output is shared, so each requester only sees it on its own return.
  assign a_if.gnt    = w_a_gnt;
  assign a_if.rvalid = a_rvalid_q;
  assign a_if.rdata  = a_rvalid_q ? ram_dout_i : '0;

  assign b_if.gnt    = w_b_gnt;
  assign b_if.rvalid = b_rvalid_q;
  assign b_if.rdata  = b_rvalid_q ? ram_dout_i : '0;

  assign conflict_cnt_o = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed bench for dmem_arbiter with a behavioural 4K x 32
//               synchronous RAM attached to the arbiter's RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [15:0] conflict_cnt;
  logic [31:0] mem [0:4095];

  int n_asserts = 0;
  int n_fail    = 0;

  logic exp_b, prev_a, prev_b;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) a_bus ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) b_bus ();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clock_i        (clk),
    .reset_ni       (reset_n),
    .a_if           (a_bus),
    .b_if           (b_bus),
    .ram_wen_o      (ram_wen),
    .ram_addr_o     (ram_addr),
    .ram_din_o      (ram_din),
    .ram_dout_i     (ram_dout),
    .conflict_cnt_o (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for three edges with both requesters active and writing.
    reset_n = 1'b0;
    a_bus.req = 1'b1; a_bus.we = 1'b1; a_bus.addr = 12'h03C; a_bus.wdata = 32'h1234;
    b_bus.req = 1'b1; b_bus.we = 1'b1; b_bus.addr = 12'h03D; b_bus.wdata = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_a_gnt",    a_bus.gnt,    0);
      chk("rst_b_gnt",    b_bus.gnt,    0);
      chk("rst_ram_wen",  ram_wen,      0);
      chk("rst_a_rvalid", a_bus.rvalid, 0);
      chk("rst_b_rvalid", b_bus.rvalid, 0);
      chk("rst_conflict", conflict_cnt, 0);
      @(negedge clk);
    end

    // Release with no requests: everything idle.
    reset_n = 1'b1;
    a_bus.req = 1'b0; a_bus.we = 1'b0;
    b_bus.req = 1'b0; b_bus.we = 1'b0;
    #1;
    chk("idle_a_gnt",    a_bus.gnt, 0);
    chk("idle_b_gnt",    b_bus.gnt, 0);
    chk("idle_ram_addr", ram_addr,  0);
    chk("idle_ram_din",  ram_din,   0);
    chk("idle_ram_wen",  ram_wen,   0);
    @(negedge clk);

    // Uncontested A write, then read-back of the same address.
    a_bus.req = 1'b1; a_bus.we = 1'b1; a_bus.addr = 12'h010; a_bus.wdata = 32'hDEADBEEF;
    #1;
    chk("wr_a_gnt",    a_bus.gnt, 1);
    chk("wr_b_gnt",    b_bus.gnt, 0);
    chk("wr_ram_wen",  ram_wen,   1);
    chk("wr_ram_addr", ram_addr,  32'h010);
    chk("wr_ram_din",  ram_din,   32'hDEADBEEF);
    @(negedge clk);
    a_bus.we = 1'b0; a_bus.wdata = 32'h0;
    #1;
    chk("rd_a_gnt",      a_bus.gnt,    1);
    chk("rd_ram_wen",    ram_wen,      0);
    chk("wr_no_rvalid",  a_bus.rvalid, 0);
    @(negedge clk);
    a_bus.req = 1'b0;
    #1;
    chk("rd_a_rvalid", a_bus.rvalid, 1);
    chk("rd_a_rdata",  a_bus.rdata,  32'hDEADBEEF);
    chk("rd_b_rvalid", b_bus.rvalid, 0);
    chk("rd_b_rdata",  b_bus.rdata,  0);
    @(negedge clk);
    #1;
    chk("rd_rvalid_drop", a_bus.rvalid, 0);
    chk("rd_rdata_zero",  a_bus.rdata,  0);

    // Preload 0x001 = 0x11 and 0x002 = 0x22 through port A.
    a_bus.req = 1'b1; a_bus.we = 1'b1; a_bus.addr = 12'h001; a_bus.wdata = 32'h11;
    @(negedge clk);
    a_bus.addr = 12'h002; a_bus.wdata = 32'h22;
    @(negedge clk);

    // Both reading continuously: A,A,A,A,B,A,A,A,A,B,A,A with tagged returns.
    a_bus.we = 1'b0; a_bus.addr = 12'h001; a_bus.wdata = 32'h0;
    b_bus.req = 1'b1; b_bus.we = 1'b0; b_bus.addr = 12'h002; b_bus.wdata = 32'h0;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_b = (i == 4) || (i == 9);
      #1;
      chk("starve_a_gnt",    a_bus.gnt,    {31'd0, !exp_b});
      chk("starve_b_gnt",    b_bus.gnt,    {31'd0, exp_b});
      chk("inter_a_rvalid",  a_bus.rvalid, {31'd0, prev_a});
      chk("inter_b_rvalid",  b_bus.rvalid, {31'd0, prev_b});
      chk("inter_a_rdata",   a_bus.rdata,  prev_a ? 32'h11 : 32'h0);
      chk("inter_b_rdata",   b_bus.rdata,  prev_b ? 32'h22 : 32'h0);
      chk("starve_conflict", conflict_cnt, i);
      prev_a = !exp_b; prev_b = exp_b;
      @(negedge clk);
    end
    a_bus.req = 1'b0; b_bus.req = 1'b0;
    #1;
    chk("starve_conflict12", conflict_cnt, 12);
    chk("starve_last_a_rv",  a_bus.rvalid, 1);
    chk("starve_last_a_rd",  a_bus.rdata,  32'h11);
    chk("starve_last_b_rv",  b_bus.rvalid, 0);
    @(negedge clk);

    // Build b_wait to the limit with B writing 0x5 to 0x0FF, then A reads 0x0FF.
    a_bus.req = 1'b1; a_bus.we = 1'b0; a_bus.addr = 12'h001;
    b_bus.req = 1'b1; b_bus.we = 1'b1; b_bus.addr = 12'h0FF; b_bus.wdata = 32'h5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ord_pre_a_gnt", a_bus.gnt, 1);
      chk("ord_pre_b_gnt", b_bus.gnt, 0);
      @(negedge clk);
    end
    a_bus.addr = 12'h0FF;
    #1;
    chk("ord_b_gnt",    b_bus.gnt, 1);
    chk("ord_a_gnt",    a_bus.gnt, 0);
    chk("ord_ram_wen",  ram_wen,   1);
    chk("ord_ram_addr", ram_addr,  32'h0FF);
    chk("ord_ram_din",  ram_din,   32'h5);
    @(negedge clk);
    b_bus.req = 1'b0; b_bus.we = 1'b0; b_bus.wdata = 32'h0;
    #1;
    chk("ord_a_gnt2",    a_bus.gnt,    1);
    chk("ord_b_gnt2",    b_bus.gnt,    0);
    chk("ord_ram_wen2",  ram_wen,      0);
    chk("ord_b_rvalid",  b_bus.rvalid, 0);
    @(negedge clk);
    a_bus.req = 1'b0;
    #1;
    chk("ord_a_rvalid",  a_bus.rvalid, 1);
    chk("ord_a_rdata",   a_bus.rdata,  32'h5);
    chk("ord_conflict",  conflict_cnt, 17);
    @(negedge clk);

    // Read granted to A, then reset falls before the closing edge.
    a_bus.req = 1'b1; a_bus.we = 1'b0; a_bus.addr = 12'h010;
    b_bus.req = 1'b1; b_bus.we = 1'b0; b_bus.addr = 12'h002;
    #1;
    chk("mid_a_gnt", a_bus.gnt, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_gnt_forced",  a_bus.gnt, 0);
    chk("mid_wen_forced",  ram_wen,   0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_a_rvalid", a_bus.rvalid, 0);
    chk("mid_a_rdata",  a_bus.rdata,  0);
    chk("mid_conflict", conflict_cnt, 0);
    // A cleared wait counter means B waits the full four cycles again.
    for (int i = 0; i < 5; i++) begin
      exp_b = (i == 4);
      if (i > 0) #1;
      chk("post_a_gnt", a_bus.gnt, {31'd0, !exp_b});
      chk("post_b_gnt", b_bus.gnt, {31'd0, exp_b});
      @(negedge clk);
    end
    a_bus.req = 1'b0; b_bus.req = 1'b0;
    #1;
    chk("post_conflict", conflict_cnt, 5);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
